// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_MISS = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_t;

  localparam int          FEXC_MISALIGN = 0;
  localparam int          FEXC_ACCESS   = 1;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;

  localparam logic [31:0] RESET_PC_DEFAULT       = 32'h0000_1000;
  localparam logic [31:0] EXC_HANDLER_PC_DEFAULT = 32'h0000_2000;

endpackage

// File: rtl/fetch_pc_sel.sv
// Next-PC priority mux: exception > branch > pending redirect > hold > pc+4.
module fetch_pc_sel
  import fetch_pkg::*;
#(
  parameter logic [31:0] EXC_HANDLER_PC = EXC_HANDLER_PC_DEFAULT
) (
  input  logic [31:0] pc_i,
  input  logic [31:0] pending_pc_i,
  input  logic        exception_i,
  input  logic [31:0] branch_target_i,
  input  logic        redirect_apply_i,
  input  logic        drop_done_i,
  input  logic        hold_i,
  output logic [31:0] redirect_pc_o,
  output logic [31:0] next_pc_o
);

  always_comb begin
    redirect_pc_o = exception_i ? EXC_HANDLER_PC : branch_target_i;
    if (redirect_apply_i) begin
      next_pc_o = redirect_pc_o;
    end else if (drop_done_i) begin
      next_pc_o = pending_pc_i;
    end else if (hold_i) begin
      next_pc_o = pc_i;
    end else begin
      next_pc_o = pc_i + 32'd4;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with i-cache miss/drop handling.
// Optional build macro: FETCH_MISALIGN_CHECK_EN (misaligned-PC fetch exception).
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = RESET_PC_DEFAULT,
  parameter logic [31:0] EXC_HANDLER_PC = EXC_HANDLER_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_stall,
  input  logic        in_d_cache_stall,
  input  logic        in_branch_taken,
  input  logic [31:0] in_branch_target,
  input  logic        in_exception,
  input  logic        in_icache_ready,
  input  logic [31:0] in_icache_rdata,
  input  logic        in_icache_error,
  output logic        out_icache_req,
  output logic [31:0] out_icache_addr,
  output logic [31:0] out_instruction,
  output logic [31:0] out_PC,
  output logic        out_i_cache_stall,
  output logic [2:0]  out_exception_vector
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pending_pc_q, pending_pc_d;
  logic [31:0]  redirect_pc;
  logic         misaligned, redirect, redirect_apply, hold, drop_done, deliver;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    misaligned = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    misaligned = (state_q == ST_RUN) && (pc_q[1:0] != 2'b00);
`endif
    redirect       = in_exception | in_branch_taken;
    // Outside RUN the outstanding request can only be abandoned once it completes.
    redirect_apply = redirect & ((state_q == ST_RUN) | in_icache_ready);
    hold           = in_stall | in_d_cache_stall | ~in_icache_ready | misaligned;
    drop_done      = (state_q == ST_DROP) & in_icache_ready;
    deliver        = in_icache_ready & (state_q != ST_DROP) & ~misaligned;

    out_icache_req    = ~misaligned;
`ifdef FETCH_MISALIGN_CHECK_EN
    out_icache_addr   = pc_q;
`else
    out_icache_addr   = {pc_q[31:2], 2'b00};
`endif
    out_PC            = pc_q;
    out_instruction   = deliver ? in_icache_rdata : NOP_INSTR;
    out_i_cache_stall = ~misaligned & ((state_q == ST_DROP) | ~in_icache_ready);
    out_exception_vector                = 3'b000;
    out_exception_vector[FEXC_MISALIGN] = misaligned;
    out_exception_vector[FEXC_ACCESS]   = deliver & in_icache_error;

    state_d      = state_q;
    pending_pc_d = pending_pc_q;
    case (state_q)
      ST_RUN: begin
        if (!misaligned && !redirect && !in_icache_ready) state_d = ST_MISS;
      end
      ST_MISS, ST_DROP: begin
        if (in_icache_ready) begin
          state_d = ST_RUN;
        end else if (redirect) begin
          state_d      = ST_DROP;
          pending_pc_d = redirect_pc;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  fetch_pc_sel #(
    .EXC_HANDLER_PC (EXC_HANDLER_PC)
  ) u_pc_sel (
    .pc_i             (pc_q),
    .pending_pc_i     (pending_pc_q),
    .exception_i      (in_exception),
    .branch_target_i  (in_branch_target),
    .redirect_apply_i (redirect_apply),
    .drop_done_i      (drop_done),
    .hold_i           (hold),
    .redirect_pc_o    (redirect_pc),
    .next_pc_o        (pc_d)
  );

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RUN;
      pc_q         <= RESET_PC;
      pending_pc_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pending_pc_q <= pending_pc_d;
    end
  end

endmodule
